// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Deepest memory read latency the response counter has to cover.
  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data priority select with a fetch starvation guard; produces a one-hot grant.
// Latency: combinational grant; starvation count updates on the rising edge.
// Backpressure: grants only while i_arb_en is high; a losing requester holds its request.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arb_en,
  input  logic i_if_req,
  input  logic i_dm_req,
  output logic o_if_gnt,
  output logic o_dm_gnt
);

  localparam int             SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] r_starve;
  logic          w_if_first;

  // Data normally wins; fetch wins once it has been passed over STARVE_MAX times.
  always_comb begin
    w_if_first = i_if_req && (r_starve == STARVE_LIM);
    o_if_gnt   = 1'b0;
    o_dm_gnt   = 1'b0;
    if (i_arb_en) begin
      if (w_if_first || (i_if_req && !i_dm_req)) begin
        o_if_gnt = 1'b1;
      end else if (i_dm_req) begin
        o_dm_gnt = 1'b1;
      end
    end
  end

  // Count data grants taken while fetch waits; saturate at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!i_if_req || o_if_gnt) begin
      r_starve <= '0;
    end else if (o_dm_gnt && (r_starve != STARVE_LIM)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access.
// Latency: grant and mem_* strobe in the request cycle; read data MEM_LAT cycles after grant.
// Backpressure: one read outstanding; new grants only when idle or in the response cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_RESP = CNT_W'(1);

  state_e           r_state, w_state_nxt;
  owner_e           r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_flushed, w_flushed_nxt;
  logic             w_resp, w_arb_en, w_if_gnt, w_dm_gnt, w_rd_gnt;

  // The counter reaches 1 exactly MEM_LAT cycles after the read grant.
  assign w_resp   = (r_state == RD_WAIT) && (r_cnt == CNT_RESP);
  assign w_arb_en = !rst && ((r_state == IDLE) || w_resp);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .i_arb_en (w_arb_en),
    .i_if_req (if_req),
    .i_dm_req (dm_req),
    .o_if_gnt (w_if_gnt),
    .o_dm_gnt (w_dm_gnt)
  );

  assign w_rd_gnt  = w_if_gnt || (w_dm_gnt && !dm_we);

  assign if_gnt    = w_if_gnt;
  assign dm_gnt    = w_dm_gnt;
  assign mem_en    = w_if_gnt || w_dm_gnt;
  assign mem_we    = w_dm_gnt && dm_we;
  assign mem_addr  = w_dm_gnt ? dm_addr  : if_addr;
  assign mem_wdata = w_dm_gnt ? dm_wdata : '0;
  assign mem_be    = w_dm_gnt ? dm_be    : '0;

  // A flush seen during the wait or in the response cycle itself hides the fetch data.
  assign if_rvalid = !rst && w_resp && (r_owner == OWN_IF) && !r_flushed && !if_flush;
  assign dm_rvalid = !rst && w_resp && (r_owner == OWN_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  // Next state: a read grant (re)arms the wait, else the response returns to idle.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_cnt_nxt     = r_cnt;
    w_flushed_nxt = r_flushed;
    if (w_rd_gnt) begin
      w_state_nxt   = RD_WAIT;
      w_owner_nxt   = w_if_gnt ? OWN_IF : OWN_DM;
      w_cnt_nxt     = LAT_LOAD;
      w_flushed_nxt = 1'b0;
    end else if (w_resp) begin
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_flushed_nxt = 1'b0;
    end else if (r_state == RD_WAIT) begin
      w_cnt_nxt = r_cnt - 1'b1;
      if ((r_owner == OWN_IF) && if_flush) begin
        w_flushed_nxt = 1'b1;
      end
    end
  end

  // State register; reset drops any outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= OWN_IF;
      r_cnt     <= '0;
      r_flushed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_cnt     <= w_cnt_nxt;
      r_flushed <= w_flushed_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (MEM_LAT=2 and MEM_LAT=1) against a transaction-level model.
// Latency: n/a.
// Backpressure: requesters hold each request until granted.
module tb_mem_port_arbiter;

  localparam int SMAX = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_flush  [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        dm_req    [2];
  logic        dm_we     [2];
  logic [31:0] dm_addr   [2];
  logic [31:0] dm_wdata  [2];
  logic [3:0]  dm_be     [2];
  logic        dm_gnt    [2];
  logic        dm_rvalid [2];
  logic [31:0] dm_rdata  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_be    [2];
  logic [31:0] mem_rdata [2];

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(SMAX)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_flush(if_flush[0]),
    .if_gnt(if_gnt[0]), .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_be(dm_be[0]), .dm_gnt(dm_gnt[0]), .dm_rvalid(dm_rvalid[0]), .dm_rdata(dm_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_flush(if_flush[1]),
    .if_gnt(if_gnt[1]), .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_be(dm_be[1]), .dm_gnt(dm_gnt[1]), .dm_rvalid(dm_rvalid[1]), .dm_rdata(dm_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: remembers every read strobe and returns its word MEM_LAT cycles later.
  bit          hist_rd   [2][1024];
  logic [31:0] hist_addr [2][1024];

  always @(posedge clk) begin : mem_model
    int c;
    #1;
    for (int k = 0; k < 2; k++) begin
      c = cyc - lat_of(k);
      if (c >= 0 && hist_rd[k][c % 1024]) mem_rdata[k] = mem_word(hist_addr[k][c % 1024]);
      else                                mem_rdata[k] = $urandom;
    end
  end

  // Reference model: at most one pending read, described by its due cycle.
  bit          out_vld  [2];
  bit          out_if   [2];
  bit          out_fl   [2];
  logic [31:0] out_addr [2];
  int          out_due  [2];
  int          starve   [2];
  bit          prev_if_gnt [2];
  bit          prev_dm_gnt [2];

  always @(negedge clk) begin : compare
    bit can_arb, due, e_if, e_dm, e_if_rv, e_dm_rv;
    for (int k = 0; k < 2; k++) begin
      can_arb = !rst[k] && (!out_vld[k] || out_due[k] == cyc);
      due     = !rst[k] && out_vld[k] && out_due[k] == cyc;
      e_if    = can_arb && if_req[k] && (starve[k] == SMAX || !dm_req[k]);
      e_dm    = can_arb && !e_if && dm_req[k];
      e_if_rv = due && out_if[k] && !out_fl[k] && !if_flush[k];
      e_dm_rv = due && !out_if[k];

      check($sformatf("if_gnt%0d", k),    if_gnt[k],    e_if);
      check($sformatf("dm_gnt%0d", k),    dm_gnt[k],    e_dm);
      check($sformatf("mem_en%0d", k),    mem_en[k],    e_if || e_dm);
      check($sformatf("mem_we%0d", k),    mem_we[k],    e_dm && dm_we[k]);
      check($sformatf("if_rvalid%0d", k), if_rvalid[k], e_if_rv);
      check($sformatf("dm_rvalid%0d", k), dm_rvalid[k], e_dm_rv);
      if (e_if) check($sformatf("mem_addr_if%0d", k), mem_addr[k], if_addr[k]);
      if (e_dm) begin
        check($sformatf("mem_addr_dm%0d", k),  mem_addr[k],  dm_addr[k]);
        check($sformatf("mem_wdata%0d", k),    mem_wdata[k], dm_wdata[k]);
        check($sformatf("mem_be%0d", k),       mem_be[k],    {28'd0, dm_be[k]});
      end
      if (e_if_rv) check($sformatf("if_rdata%0d", k), if_rdata[k], mem_word(out_addr[k]));
      if (e_dm_rv) check($sformatf("dm_rdata%0d", k), dm_rdata[k], mem_word(out_addr[k]));

      hist_rd[k][cyc % 1024]   = mem_en[k] && !mem_we[k];
      hist_addr[k][cyc % 1024] = mem_addr[k];

      if (rst[k]) begin
        out_vld[k] = 1'b0;
        starve[k]  = 0;
      end else begin
        if (due) out_vld[k] = 1'b0;
        else if (out_vld[k] && out_if[k] && if_flush[k]) out_fl[k] = 1'b1;
        if (e_if || (e_dm && !dm_we[k])) begin
          out_vld[k]  = 1'b1;
          out_if[k]   = e_if;
          out_fl[k]   = 1'b0;
          out_addr[k] = e_if ? if_addr[k] : dm_addr[k];
          out_due[k]  = cyc + lat_of(k);
        end
        if (!if_req[k] || e_if)             starve[k] = 0;
        else if (e_dm && starve[k] < SMAX) starve[k] = starve[k] + 1;
      end
      prev_if_gnt[k] = if_gnt[k];
      prev_dm_gnt[k] = dm_gnt[k];
    end
    cyc++;
  end

  task automatic start_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; if_req[k] = 1'b0; if_flush[k] = 1'b0;
      dm_req[k] = 1'b0; dm_we[k] = 1'b0;
    end
  endtask

  task automatic quiet(int n);
    repeat (n) begin
      start_cyc();
      clear_all();
      mid();
    end
  endtask

  task automatic rand_cycle();
    start_cyc();
    for (int k = 0; k < 2; k++) begin
      rst[k]      = ($urandom_range(0, 99) == 0);
      if_flush[k] = ($urandom_range(0, 5) == 0);
      if (!if_req[k] || prev_if_gnt[k]) begin
        if_req[k]  = ($urandom_range(0, 2) != 0);
        if_addr[k] = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_req[k] || prev_dm_gnt[k]) begin
        dm_req[k]   = ($urandom_range(0, 2) != 0);
        dm_we[k]    = ($urandom_range(0, 1) == 1);
        dm_addr[k]  = $urandom & 32'hFFFF_FFFC;
        dm_wdata[k] = $urandom;
        dm_be[k]    = 4'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin : stim
    logic [7:0]  exp_kind [6];
    logic [7:0]  got_kind [$];
    int          got_cyc  [$];
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; if_req[k] = 1'b1; if_addr[k] = 32'h10; if_flush[k] = 1'b0;
      dm_req[k] = 1'b1; dm_we[k] = 1'b0; dm_addr[k] = 32'h20; dm_wdata[k] = '0; dm_be[k] = '0;
      mem_rdata[k] = '0;
    end

    // Reset with both requests pending: everything stays quiet.
    repeat (2) begin
      mid();
      check("rst_if_gnt",  if_gnt[0],    0);
      check("rst_dm_gnt",  dm_gnt[0],    0);
      check("rst_mem_en",  mem_en[0],    0);
      check("rst_mem_we",  mem_we[0],    0);
      check("rst_rvalid",  {if_rvalid[0], dm_rvalid[0]}, 0);
      start_cyc();
    end
    clear_all();
    mid();

    // Lone data read at 0x40 returns two cycles later.
    start_cyc(); dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h40;
    mid();
    check("rd40_gnt",  dm_gnt[0],   1);
    check("rd40_en",   mem_en[0],   1);
    check("rd40_addr", mem_addr[0], 32'h40);
    start_cyc(); dm_req[0] = 0;
    mid();
    check("rd40_early", dm_rvalid[0], 0);
    start_cyc();
    mid();
    check("rd40_rvalid", dm_rvalid[0], 1);
    check("rd40_rdata",  dm_rdata[0],  mem_word(32'h40));
    quiet(2);

    // Continuous fetch and data reads: DM DM IF DM DM IF, one grant per 2 cycles.
    exp_kind = '{8'h44, 8'h44, 8'h49, 8'h44, 8'h44, 8'h49};
    start_cyc();
    if_req[0] = 1; if_addr[0] = 32'h300; dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h400;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) start_cyc();
      mid();
      if (if_gnt[0]) begin got_kind.push_back(8'h49); got_cyc.push_back(i); end
      if (dm_gnt[0]) begin got_kind.push_back(8'h44); got_cyc.push_back(i); end
    end
    check("starve_ngrants", got_kind.size(), 6);
    for (int j = 0; j < got_kind.size() && j < 6; j++) begin
      check($sformatf("starve_order%0d", j), got_kind[j], exp_kind[j]);
      if (j > 0) check($sformatf("starve_gap%0d", j), got_cyc[j] - got_cyc[j-1], 2);
    end
    quiet(3);

    // Three back-to-back writes.
    for (int i = 0; i < 3; i++) begin
      start_cyc();
      dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 32'(4 * i); dm_wdata[0] = $urandom; dm_be[0] = 4'b0011;
      mid();
      check($sformatf("wr%0d_gnt", i),  dm_gnt[0],    1);
      check($sformatf("wr%0d_we", i),   mem_we[0],    1);
      check($sformatf("wr%0d_be", i),   mem_be[0],    4'b0011);
      check($sformatf("wr%0d_rv", i),   dm_rvalid[0], 0);
    end
    quiet(1);
    check("wr_after_rv", dm_rvalid[0], 0);
    quiet(1);

    // Flushed fetch is hidden; the next fetch granted in its response cycle returns.
    start_cyc(); if_req[0] = 1; if_addr[0] = 32'h100;
    mid(); check("fl_gnt1", if_gnt[0], 1);
    start_cyc(); if_req[0] = 0; if_flush[0] = 1;
    mid(); check("fl_rv_t1", if_rvalid[0], 0);
    start_cyc(); if_flush[0] = 0; if_req[0] = 1; if_addr[0] = 32'h200;
    mid();
    check("fl_rv_t2",  if_rvalid[0], 0);
    check("fl_gnt2",   if_gnt[0],    1);
    start_cyc(); if_req[0] = 0;
    mid();
    start_cyc();
    mid();
    check("fl_rv_t4",    if_rvalid[0], 1);
    check("fl_rdata_t4", if_rdata[0],  mem_word(32'h200));
    quiet(2);

    // Reset one cycle after a read grant discards the response.
    start_cyc(); dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h80;
    mid(); check("mr_gnt", dm_gnt[0], 1);
    start_cyc(); rst[0] = 1; dm_addr[0] = 32'hC0;
    mid();
    check("mr_rst_gnt", {if_gnt[0], dm_gnt[0]}, 0);
    check("mr_rst_en",  {mem_en[0], mem_we[0]}, 0);
    check("mr_rst_rv",  {if_rvalid[0], dm_rvalid[0]}, 0);
    start_cyc(); rst[0] = 0;
    mid();
    check("mr_t2_rv",  dm_rvalid[0], 0);
    check("mr_t2_gnt", dm_gnt[0],    1);
    start_cyc(); dm_req[0] = 0;
    mid(); check("mr_t3_rv", dm_rvalid[0], 0);
    start_cyc();
    mid();
    check("mr_new_rv",    dm_rvalid[0], 1);
    check("mr_new_rdata", dm_rdata[0],  mem_word(32'hC0));
    quiet(2);

    // MEM_LAT=1: a read every cycle, each response aligned to the previous address.
    for (int i = 0; i < 8; i++) begin
      start_cyc();
      dm_req[1] = 1; dm_we[1] = 0; dm_addr[1] = 32'h1000 + 32'(4 * i);
      mid();
      check($sformatf("l1_gnt%0d", i), dm_gnt[1], 1);
      if (i > 0) begin
        check($sformatf("l1_rv%0d", i),    dm_rvalid[1], 1);
        check($sformatf("l1_rdata%0d", i), dm_rdata[1],  mem_word(32'h1000 + 32'(4 * (i - 1))));
      end
    end
    quiet(3);

    // Randomized traffic on both instances, checked every cycle by the model.
    repeat (1500) rand_cycle();
    quiet(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
